// File: rtl/fpu_sched_pkg.sv
// Shared constants and state encoding for the FPU request scheduler.
package fpu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam int DEF_SETTLE  = 2;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps, first requester found wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_req_scheduler.sv
// Shares one FPU between N requesters with round-robin arbitration.
// Optional watchdog on the FPU done wait: define FPU_SCHED_TIMEOUT_EN.
module fpu_req_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int X       = 32,
    parameter int N       = 2,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*X-1:0] req_a,
    input  logic [N*X-1:0] req_b,
    input  logic [2*N-1:0] req_opcode,
    output logic [N-1:0]   resp_valid,
    input  logic [N-1:0]   resp_ready,
    output logic [X-1:0]   resp_data,
    output logic           resp_overflow,
    output logic           resp_underflow,
    output logic           resp_error,
    output logic [X-1:0]   fpu_a,
    output logic [X-1:0]   fpu_b,
    output logic [1:0]     fpu_opcode,
    input  logic [X-1:0]   fpu_out,
    input  logic           fpu_done,
    input  logic           fpu_overflow,
    input  logic           fpu_underflow,
    output logic           busy,
    output logic [1:0]     dbg_state_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + SETTLE + 2);

    sched_state_e  state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [X-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]    op_q, op_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          err_q, err_d;
    logic [N-1:0]  arb_grant;
    logic [PW-1:0] arb_idx;
    logic          done_ok;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // A done seen during the settle window belongs to the previous operation.
    assign done_ok = fpu_done && (cnt_q >= CW'(SETTLE));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        err_d      = err_q;
        req_ready  = '0;
        resp_valid = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = arb_grant;
                    gnt_d     = arb_idx;
                    a_d       = req_a[arb_idx*X +: X];
                    b_d       = req_b[arb_idx*X +: X];
                    op_d      = req_opcode[arb_idx*2 +: 2];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_ok) begin
                    res_d   = fpu_out;
                    ovf_d   = fpu_overflow;
                    unf_d   = fpu_underflow;
                    err_d   = 1'b0;
                    state_d = RESP;
`ifdef FPU_SCHED_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = cnt_q + 1'b1;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                end else if (cnt_q < CW'(SETTLE)) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                if (resp_ready[gnt_q]) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == PW'(N - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    assign fpu_a          = a_q;
    assign fpu_b          = b_q;
    assign fpu_opcode     = op_q;
    assign resp_data      = res_q;
    assign resp_overflow  = ovf_q;
    assign resp_underflow = unf_q;
`ifdef FPU_SCHED_TIMEOUT_EN
    assign resp_error     = err_q;
`else
    assign resp_error     = 1'b0;
`endif
    assign busy           = (state_q != IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: doc/fpu_req_scheduler.md
# fpu_req_scheduler

Shares a single FPU instance (add/sub/mul/div, 2-bit opcode) between N requesters. Requests arrive on per-requester valid/ready handshakes. A round-robin arbiter grants one requester at a time. The block captures its operands, drives the FPU, waits for `done` and returns the result with its overflow/underflow flags to the granted requester. It sits between the client units and the FPU: the FPU's A/B/opcode inputs come only from this block.

## Interface
- `X`, 32: operand/result width.
- `N`, 2: number of requesters (2..8).
- `SETTLE`, 2: cycles after issue during which `fpu_done` is ignored (masks stale `done` from the previous op).
- `TIMEOUT`, 64: watchdog limit in WAIT cycles (used only with the macro).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in N: request pending, one bit per requester.
- `req_ready` out N: one-hot, one-cycle accept pulse.
- `req_a`, `req_b` in N*X: operands; requester i occupies bits [i*X +: X].
- `req_opcode` in 2N: opcode; requester i occupies bits [2i +: 2]. 00 add, 01 sub, 10 mul, 11 div.
- `resp_valid` out N: one-hot, response for requester i.
- `resp_ready` in N: requester i accepts its response.
- `resp_data` out X: result.
- `resp_overflow`, `resp_underflow`, `resp_error` out 1: flags for the current response.
- `fpu_a`, `fpu_b` out X: FPU operands.
- `fpu_opcode` out 2: FPU opcode.
- `fpu_out` in X: FPU result.
- `fpu_done`, `fpu_overflow`, `fpu_underflow` in 1: FPU status.
- `busy` out 1: state is not IDLE.

## Operation
- States:
  - IDLE: if any `req_valid`, the arbiter picks winner g, pulses `req_ready[g]` and registers a/b/opcode and g. Next state ISSUE.
  - ISSUE: FPU inputs are already driven from the registers. Clear the wait counter. Next state WAIT.
  - WAIT: increment the counter each cycle. Ignore `fpu_done` while counter < SETTLE. Once counter ≥ SETTLE and `fpu_done`=1, register `fpu_out` and the flags. Next state RESP.
  - RESP: assert `resp_valid[g]` and hold all `resp_*` stable until `resp_ready[g]`. Then go to IDLE and set the round-robin pointer to g+1 mod N.
- Round-robin: search starts at the pointer. Reset pointer = 0. A requester granted last has lowest priority next round.
- `fpu_a`, `fpu_b` and `fpu_opcode` stay constant from ISSUE through RESP. They change only at the next accept.
- `resp_ready` bits of non-granted requesters are ignored. `req_valid` is ignored outside IDLE, and `req_ready` is 0 outside IDLE.
- Reset in any state: go to IDLE and drop any in-flight op; no response is issued for it.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_data`=0, all flags 0, `fpu_a`=`fpu_b`=0, `fpu_opcode`=00, `busy`=0, pointer=0.
- Sequence: accept at cycle T (IDLE) → ISSUE at T+1 → WAIT from T+2.
- `fpu_done` is first eligible at T+2+SETTLE. If sampled high in cycle S, `resp_valid` is high from S+1.
- Minimum accept-to-`resp_valid` = SETTLE+3 cycles. Minimum between back-to-back accepts = SETTLE+4 cycles with `resp_ready` held high.
- Response handshake completes in the cycle where `resp_valid[g]` and `resp_ready[g]` are both high. A new accept is possible the following cycle.

## Configuration
- `FPU_SCHED_TIMEOUT_EN` defined: if the WAIT counter reaches TIMEOUT without an eligible `fpu_done`, go to RESP with `resp_data`=0, `resp_error`=1, overflow/underflow=0.
- `FPU_SCHED_TIMEOUT_EN` undefined: WAIT stays until `done`. `resp_error` is tied to 0 and the counter saturates at SETTLE.

## Structure
- Package `fpu_sched_pkg`:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - state enum IDLE/ISSUE/WAIT/RESP.
  - default SETTLE/TIMEOUT constants.
- Sub-module `rr_arbiter` (parameter N): inputs `req`[N] and `ptr`; outputs one-hot `grant` and its index. Purely combinational. The pointer register stays in the top level.

## Test plan
- Requester 0, opcode 00, A=0x3F800000, B=0x40000000, FPU model done after 3 cycles → `resp_valid`=01, `resp_data`=0x40400000, flags 0, latency matches the formula.
- Requester 1, opcode 10, A=0x40000000, B=0x40400000 → `resp_valid`=10, `resp_data`=0x40C00000.
- Both requesters valid in the same cycle from reset → grants go 0, 1, 0, 1 over four ops. `req_ready` is never two-hot.
- `resp_ready` low for 5 cycles in RESP → `resp_valid` and `resp_data` stable, no new `req_ready`. Resume on `resp_ready`.
- `reset` asserted in WAIT → next cycle all outputs at reset values. A subsequent op (A=0x40400000, B=0x3F800000, opcode 01) returns 0x40000000.
- With `FPU_SCHED_TIMEOUT_EN`, TIMEOUT=16, `fpu_done` held 0 → RESP entered after 16 WAIT cycles with `resp_error`=1 and `resp_data`=0.
